// File: rtl/run_controller.sv
// Execution controller: gates the core clock-enable, counts enabled cycles, stops on halt/breakpoint/timeout.
// CoreEnable is combinational (0 latency, stop blocks the same cycle); status outputs are registered; no backpressure.
module run_controller #(
    parameter int                     PC_WIDTH    = 8,
    parameter int                     INSTR_WIDTH = 8,
    parameter logic [INSTR_WIDTH-1:0] HALT_OPCODE = '0,
    parameter int                     CYCLE_WIDTH = 16,
    parameter int                     MAX_CYCLES  = 500
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Start,
    input  logic                   Step,
    input  logic                   Abort,
    input  logic                   Clear,
    input  logic                   BreakEn,
    input  logic [PC_WIDTH-1:0]    BreakPC,
    input  logic [PC_WIDTH-1:0]    PC,
    input  logic [INSTR_WIDTH-1:0] Instrucao,
    output logic                   CoreEnable,
    output logic                   Running,
    output logic                   Halted,
    output logic [1:0]             HaltCause,
    output logic [CYCLE_WIDTH-1:0] CycleCount
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_STEP   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_HALT  = 2'b01;
    localparam logic [1:0] CAUSE_BREAK = 2'b10;
    localparam logic [1:0] CAUSE_TMO   = 2'b11;

    localparam logic [CYCLE_WIDTH-1:0] MAX_CNT = CYCLE_WIDTH'(MAX_CYCLES);
    localparam logic [CYCLE_WIDTH-1:0] CNT_ONE = CYCLE_WIDTH'(1);

    state_t                 state, state_nxt;
    logic [1:0]             halt_cause, halt_cause_nxt;
    logic [CYCLE_WIDTH-1:0] cycle_count, cycle_count_nxt;
    logic                   skip_bp, skip_bp_nxt;

    logic       active;
    logic       hit_halt, hit_bp, hit_to;
    logic       stop;
    logic [1:0] stop_cause;
    logic       core_en;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= S_IDLE;
            halt_cause  <= CAUSE_NONE;
            cycle_count <= '0;
            skip_bp     <= 1'b0;
        end else begin
            state       <= state_nxt;
            halt_cause  <= halt_cause_nxt;
            cycle_count <= cycle_count_nxt;
            skip_bp     <= skip_bp_nxt;
        end
    end

    // Stop detection and enable gating; a halt instruction is never executed.
    always_comb begin
        active     = (state == S_RUN) || (state == S_STEP);
        hit_halt   = (Instrucao == HALT_OPCODE);
        hit_bp     = BreakEn && (PC == BreakPC) && !skip_bp;
        hit_to     = (MAX_CYCLES != 0) && (cycle_count == MAX_CNT);
        stop       = active && (hit_halt || hit_bp || hit_to);
        stop_cause = hit_halt ? CAUSE_HALT : (hit_bp ? CAUSE_BREAK : CAUSE_TMO);
        core_en    = active && !stop && !Abort && !Clear;
    end

    always_comb begin
        state_nxt       = state;
        halt_cause_nxt  = halt_cause;
        skip_bp_nxt     = skip_bp;
        cycle_count_nxt = core_en ? cycle_count + CNT_ONE : cycle_count;
        if (core_en) begin
            skip_bp_nxt = 1'b0;
        end

        if (Clear) begin
            state_nxt       = S_IDLE;
            halt_cause_nxt  = CAUSE_NONE;
            skip_bp_nxt     = 1'b0;
            cycle_count_nxt = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!Abort) begin
                        if (Start) begin
                            state_nxt = S_RUN;
                        end else if (Step) begin
                            state_nxt = S_STEP;
                        end
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state_nxt      = S_HALTED;
                        halt_cause_nxt = stop_cause;
                    end else if (Abort) begin
                        state_nxt      = S_IDLE;
                        halt_cause_nxt = CAUSE_NONE;
                    end
                end
                S_STEP: begin
                    if (stop) begin
                        state_nxt      = S_HALTED;
                        halt_cause_nxt = stop_cause;
                    end else if (Abort || core_en) begin
                        state_nxt = S_IDLE;
                    end
                end
                S_HALTED: begin
                    // Only a breakpoint stop is resumable; resume steps past the breakpoint once.
                    if ((halt_cause == CAUSE_BREAK) && !Abort && (Start || Step)) begin
                        state_nxt      = Start ? S_RUN : S_STEP;
                        halt_cause_nxt = CAUSE_NONE;
                        skip_bp_nxt    = 1'b1;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign CoreEnable = core_en;
    assign Running    = active;
    assign Halted     = (state == S_HALTED);
    assign HaltCause  = halt_cause;
    assign CycleCount = cycle_count;

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: a toy core (PC + instruction memory) driven by CoreEnable,
// checked against a program-scanning reference of where and why execution stops.
module tb_run_controller;

    localparam int MAX = 10;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        Step = 1'b0;
    logic        Abort = 1'b0;
    logic        Clear = 1'b0;
    logic        BreakEn = 1'b0;
    logic [7:0]  BreakPC = 8'd0;
    logic [7:0]  pc = 8'd0;
    logic [7:0]  instr;
    logic        core_en;
    logic        running;
    logic        halted;
    logic [1:0]  halt_cause;
    logic [15:0] cycle_count;

    logic [7:0]  mem [256];
    logic        pc_load = 1'b0;
    logic [7:0]  pc_init = 8'd0;
    int          en_cnt = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    run_controller #(
        .PC_WIDTH(8), .INSTR_WIDTH(8), .HALT_OPCODE(8'h00), .CYCLE_WIDTH(16), .MAX_CYCLES(MAX)
    ) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Step(Step), .Abort(Abort), .Clear(Clear),
        .BreakEn(BreakEn), .BreakPC(BreakPC), .PC(pc), .Instrucao(instr),
        .CoreEnable(core_en), .Running(running), .Halted(halted),
        .HaltCause(halt_cause), .CycleCount(cycle_count)
    );

    always #5 Clock = ~Clock;

    assign instr = mem[pc];

    // Toy core: advances one instruction per enabled cycle.
    always @(posedge Clock) begin
        if (pc_load)            pc <= pc_init;
        else if (Reset)         pc <= 8'd0;
        else if (core_en)       pc <= pc + 8'd1;
        if (!Reset && core_en)  en_cnt <= en_cnt + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: walk the program from start_pc and report where/why it stops.
    function automatic void predict(input int start_pc, input int start_cnt, input bit skip,
                                    output int stop_pc, output int cnt, output int cause);
        int p;
        bit sk;
        p = start_pc;
        cnt = start_cnt;
        sk = skip;
        cause = 0;
        for (int guard = 0; guard < 1000 && cause == 0; guard++) begin
            if (mem[p[7:0]] == 8'h00)                         cause = 1;
            else if (BreakEn && (p == int'(BreakPC)) && !sk)  cause = 2;
            else if (cnt == MAX)                              cause = 3;
            else begin
                p = (p + 1) % 256;
                cnt++;
                sk = 1'b0;
            end
        end
        stop_pc = p;
    endfunction

    task automatic fill_prog(input int halt_at);
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(1, 255));
        if (halt_at >= 0) mem[halt_at] = 8'h00;
    endtask

    task automatic load_pc(input int v);
        pc_init = 8'(v);
        pc_load = 1'b1;
        @(negedge Clock);
        pc_load = 1'b0;
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
    endtask

    task automatic pulse_clear();
        Clear = 1'b1;
        @(negedge Clock);
        Clear = 1'b0;
    endtask

    task automatic wait_halt(input int budget);
        int n;
        n = 0;
        while (!halted && n < budget) begin
            @(negedge Clock);
            n++;
        end
        if (!halted) check("halt_wait_expired", 0, 1);
    endtask

    task automatic check_stop(input string tag, input int exp_pc, input int exp_cnt,
                              input int exp_cause, input int exp_en);
        check({tag, "_halted"}, int'(halted), 1);
        check({tag, "_cause"}, int'(halt_cause), exp_cause);
        check({tag, "_count"}, int'(cycle_count), exp_cnt);
        check({tag, "_pc"}, int'(pc), exp_pc);
        check({tag, "_ce"}, int'(core_en), 0);
        check({tag, "_enables"}, en_cnt, exp_en);
    endtask

    initial begin
        int ppc, pcnt, pcause, base, sp, n;

        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        check("rst_ce", int'(core_en), 0);
        check("rst_running", int'(running), 0);
        check("rst_halted", int'(halted), 0);
        check("rst_cause", int'(halt_cause), 0);
        check("rst_count", int'(cycle_count), 0);

        // 1: run to halt opcode at PC 5
        fill_prog(5);
        load_pc(0);
        base = en_cnt;
        pulse_start();
        check("t1_running", int'(running), 1);
        wait_halt(50);
        predict(0, 0, 1'b0, ppc, pcnt, pcause);
        check_stop("t1", ppc, pcnt, pcause, base + pcnt);

        // 2: breakpoint at 3, then resume past it to the halt
        pulse_clear();
        BreakEn = 1'b1;
        BreakPC = 8'd3;
        load_pc(0);
        base = en_cnt;
        pulse_start();
        wait_halt(50);
        predict(0, 0, 1'b0, ppc, pcnt, pcause);
        check_stop("t2_bp", ppc, pcnt, pcause, base + pcnt);
        pulse_start();
        check("t2_resume_cause", int'(halt_cause), 0);
        wait_halt(50);
        predict(ppc, pcnt, 1'b1, ppc, pcnt, pcause);
        check_stop("t2_res", ppc, pcnt, pcause, base + pcnt);

        // 3: timeout with no halt opcode
        pulse_clear();
        BreakEn = 1'b0;
        fill_prog(-1);
        load_pc(0);
        base = en_cnt;
        pulse_start();
        wait_halt(50);
        predict(0, 0, 1'b0, ppc, pcnt, pcause);
        check_stop("t3", ppc, pcnt, pcause, base + pcnt);
        pulse_start();
        repeat (2) @(negedge Clock);
        check("t3_ign_halted", int'(halted), 1);
        check("t3_ign_running", int'(running), 0);
        check("t3_ign_cause", int'(halt_cause), 3);
        check("t3_ign_count", int'(cycle_count), MAX);
        pulse_clear();
        check("t3_clr_halted", int'(halted), 0);
        check("t3_clr_running", int'(running), 0);
        check("t3_clr_cause", int'(halt_cause), 0);
        check("t3_clr_count", int'(cycle_count), 0);

        // 4: three single steps
        load_pc(0);
        base = en_cnt;
        for (int k = 0; k < 3; k++) begin
            Step = 1'b1;
            @(negedge Clock);
            Step = 1'b0;
            check("t4_step_running", int'(running), 1);
            check("t4_step_ce", int'(core_en), 1);
            @(negedge Clock);
            check("t4_back_running", int'(running), 0);
            check("t4_back_halted", int'(halted), 0);
            repeat (3) @(negedge Clock);
        end
        check("t4_count", int'(cycle_count), 3);
        check("t4_enables", en_cnt - base, 3);
        check("t4_pc", int'(pc), 3);

        // 5: Abort beats Start in RUN, then Reset beats Start
        pulse_clear();
        load_pc(0);
        pulse_start();
        n = 0;
        while (cycle_count != 16'd7 && n < 50) begin
            @(negedge Clock);
            n++;
        end
        check("t5_reach7", int'(cycle_count), 7);
        Abort = 1'b1;
        Start = 1'b1;
        #1;
        check("t5_abort_ce", int'(core_en), 0);
        @(negedge Clock);
        Abort = 1'b0;
        Start = 1'b0;
        check("t5_abort_running", int'(running), 0);
        check("t5_abort_halted", int'(halted), 0);
        check("t5_abort_count", int'(cycle_count), 7);
        Reset = 1'b1;
        Start = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        Start = 1'b0;
        check("t5_rst_running", int'(running), 0);
        check("t5_rst_halted", int'(halted), 0);
        check("t5_rst_cause", int'(halt_cause), 0);
        check("t5_rst_count", int'(cycle_count), 0);
        check("t5_rst_ce", int'(core_en), 0);

        // Random programs, breakpoints and start addresses
        for (int it = 0; it < 30; it++) begin
            pulse_clear();
            fill_prog(($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 15)));
            BreakEn = 1'($urandom_range(0, 1));
            BreakPC = 8'($urandom_range(0, 15));
            sp = int'($urandom_range(0, 3));
            load_pc(sp);
            base = en_cnt;
            pulse_start();
            wait_halt(60);
            predict(sp, 0, 1'b0, ppc, pcnt, pcause);
            check_stop("rnd", ppc, pcnt, pcause, base + pcnt);
            if (pcause == 2) begin
                pulse_start();
                wait_halt(60);
                predict(ppc, pcnt, 1'b1, ppc, pcnt, pcause);
                check_stop("rnd_res", ppc, pcnt, pcause, base + pcnt);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/run_controller.md
Name: run_controller

Overview:
- Synthesizable execution controller for the nRisc core.
- Gates the core's clock-enable and counts executed cycles.
- Stops execution on three conditions: a halt opcode, a PC breakpoint, or a cycle-limit timeout.
- Supports free-run and single-step modes, so bench-level halt/timeout logic moves into hardware for FPGA bring-up.

Parameters:
- PC_WIDTH, 8, width of PC and BreakPC.
- INSTR_WIDTH, 8, width of the fetched instruction.
- HALT_OPCODE, 8'b00000000, instruction value that halts execution.
- CYCLE_WIDTH, 16, width of CycleCount.
- MAX_CYCLES, 500, timeout limit in enabled cycles; 0 disables timeout; must be < 2^CYCLE_WIDTH.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  pulse: begin or resume free-run.
- Step  in  1  pulse: execute exactly one instruction.
- Abort  in  1  pulse: stop execution, return to IDLE.
- Clear  in  1  pulse: clear counters and cause, return to IDLE.
- BreakEn  in  1  breakpoint enable.
- BreakPC  in  PC_WIDTH  breakpoint address.
- PC  in  PC_WIDTH  current core PC.
- Instrucao  in  INSTR_WIDTH  instruction currently fetched at PC.
- CoreEnable  out  1  core advances one instruction this cycle when 1.
- Running  out  1  state is RUN or STEP.
- Halted  out  1  state is HALTED.
- HaltCause  out  2  00 none, 01 halt opcode, 10 breakpoint, 11 timeout.
- CycleCount  out  CYCLE_WIDTH  number of cycles with CoreEnable=1.

Behaviour:
Reset and state machine:
- Reset (synchronous, active-high, overrides all inputs): state IDLE, CoreEnable=0, Running=0, Halted=0, HaltCause=00, CycleCount=0, internal skip_bp=0.
- States: IDLE, RUN, STEP, HALTED.

Stop condition (combinational, evaluated only in RUN/STEP):
- hit_halt = (Instrucao == HALT_OPCODE).
- hit_bp = BreakEn && (PC == BreakPC) && !skip_bp.
- hit_to = (MAX_CYCLES != 0) && (CycleCount == MAX_CYCLES).
- stop = hit_halt | hit_bp | hit_to.
- Cause priority: halt > breakpoint > timeout.

CoreEnable and counting:
- CoreEnable = (state is RUN or STEP) && !stop && !Abort && !Clear. It is combinational, so a stop condition blocks execution in the same cycle; a halt instruction is never executed.
- CycleCount increments by 1 on every edge where CoreEnable=1.
- skip_bp is set on entry to RUN/STEP from HALTED with cause 10, and cleared after the first cycle with CoreEnable=1. This lets a resume step past the breakpoint it stopped on.

Transitions:
- IDLE: Start → RUN; else Step → STEP. Start wins if both are asserted. Start/Step do not clear counters.
- RUN: stop → HALTED, HaltCause latched. Abort → IDLE, HaltCause=00. Otherwise stay in RUN.
- STEP: stop → HALTED, cause latched. Otherwise, after exactly one CoreEnable=1 cycle → IDLE.
- HALTED: if HaltCause=10, Start → RUN and Step → STEP (resume; HaltCause cleared on exit). If HaltCause is 01 or 11, Start/Step are ignored until Clear.
- Clear, in any state: CycleCount=0, HaltCause=00, skip_bp=0, state IDLE. Clear beats Abort; Abort beats Start/Step.
- Reset beats everything. Reset mid-run drops CoreEnable to 0 at the next edge and counters return to 0.

Boundary cases:
- Timeout boundary: exactly MAX_CYCLES instructions execute before HALTED/11.
- CycleCount never wraps, because MAX_CYCLES < 2^CYCLE_WIDTH. With MAX_CYCLES=0, CycleCount wraps modulo 2^CYCLE_WIDTH.
- Breakpoint and halt opcode at the same PC: cause=01.
- Outputs Running, Halted and HaltCause are registered state decodes and reflect the state after the edge.

Test Plan:
1. Reset, then Start; instruction stream is non-zero for PCs 0..4 and 8'h00 at PC=5 (PC advances by 1 per enabled cycle). Expect 5 CoreEnable cycles, then Halted=1, HaltCause=01, CycleCount=5, CoreEnable=0 while PC=5.
2. BreakEn=1, BreakPC=3, Start. Expect a stop at PC=3 with HaltCause=10 and CycleCount=3. Pulse Start again: expect PC 3 to execute (skip_bp), then the run continues to the halt at PC=5 with HaltCause=01 and CycleCount=5.
3. MAX_CYCLES=10, no halt opcode in the stream, Start. Expect exactly 10 enabled cycles, then HaltCause=11 and CycleCount=10. Start in HALTED is ignored; Clear gives IDLE, CycleCount=0, HaltCause=00.
4. From IDLE, pulse Step three times with 4 idle cycles between pulses. Expect exactly one CoreEnable cycle per pulse, state returns to IDLE each time, and CycleCount=3.
5. In RUN at CycleCount=7, assert Abort and Start together. Expect IDLE, CoreEnable=0 that cycle, CycleCount=7. Then assert Reset and Start together: expect IDLE with all outputs 0.
